// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Receive side of a 2-digit multiplexed 7-segment bus (com/seg).
//            Synchronises the pins, rejects short scan-transition glitches,
//            and decodes each stable digit frame back into a hex value held
//            in a per-digit register.
// Ports    : sys_clk  - system clock, rising edge
//            sys_rst  - asynchronous active-high reset
//            com[1:0] - digit select, com[0]=digit0, com[1]=digit1
//            seg[7:0] - segment lines {dp,g,f,e,d,c,b,a}
//            digit0/1 - last accepted hex value per digit
//            dp[1:0]  - last accepted decimal point per digit (1 = lit)
//            valid    - digit holds a decoded value (0 = never seen / blank)
//            upd      - one-cycle pulse when a frame is committed
//            upd_idx  - digit index of the commit flagged by upd
//            err      - one-cycle pulse: both digits selected or bad pattern
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int COM_ACT_LOW   = 1,
    parameter int SEG_ACT_LOW   = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] com,
    input  logic [7:0] seg,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] dp,
    output logic [1:0] valid,
    output logic       upd,
    output logic       upd_idx,
    output logic       err
);

    localparam int              c_CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] c_ST_WAIT = 1'b0;
    localparam logic [0:0] c_ST_LOCK = 1'b1;

    // Polarity is normalised ahead of the synchroniser (per-bit inverters
    // only) so the sync/sample registers can reset to "nothing selected,
    // nothing lit", which the frame evaluator treats as a no-op.
    logic [1:0]   w_sel_n;
    logic [7:0]   w_lit_n;

    assign w_sel_n = (COM_ACT_LOW != 0) ? ~com : com;
    assign w_lit_n = (SEG_ACT_LOW != 0) ? ~seg : seg;

    // {sel[1:0], lit[7:0]}
    logic [9:0]          r_sync1;
    logic [9:0]          r_sync2;
    logic [9:0]          r_prev;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [0:0]          r_state;

    logic                w_change;
    logic [0:0]          w_state_nxt;
    logic                w_eval;

    assign w_change = (r_sync2 != r_prev);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= {w_sel_n, w_lit_n};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_change) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: WAIT evaluates the frame once the counter saturates, LOCK holds
    // until the sample changes. If the sample changes in the very cycle the
    // frame is evaluated, stay in WAIT so the new pattern is not swallowed.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= c_ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        case (r_state)
            c_ST_WAIT: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_eval      = 1'b1;
                    w_state_nxt = w_change ? c_ST_WAIT : c_ST_LOCK;
                end
            end
            c_ST_LOCK: begin
                if (w_change) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            default: w_state_nxt = c_ST_WAIT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Segment decode on the stable sample, {g..a} active-high
    // ------------------------------------------------------------------------
    logic [3:0] w_hex;
    logic       w_hit;

    always_comb begin
        w_hex = 4'h0;
        w_hit = 1'b1;
        case (r_prev[6:0])
            7'h3F: w_hex = 4'h0;
            7'h06: w_hex = 4'h1;
            7'h5B: w_hex = 4'h2;
            7'h4F: w_hex = 4'h3;
            7'h66: w_hex = 4'h4;
            7'h6D: w_hex = 4'h5;
            7'h7D: w_hex = 4'h6;
            7'h07: w_hex = 4'h7;
            7'h7F: w_hex = 4'h8;
            7'h6F: w_hex = 4'h9;
            7'h77: w_hex = 4'hA;
            7'h7C: w_hex = 4'hB;
            7'h39: w_hex = 4'hC;
            7'h5E: w_hex = 4'hD;
            7'h79: w_hex = 4'hE;
            7'h71: w_hex = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame evaluation and result registers
    // ------------------------------------------------------------------------
    logic [3:0] r_digit0, r_digit1;
    logic [1:0] r_dp, r_valid;
    logic       r_upd, r_upd_idx, r_err;

    logic [3:0] w_digit0_nxt, w_digit1_nxt;
    logic [1:0] w_dp_nxt, w_valid_nxt;
    logic       w_upd_nxt, w_upd_idx_nxt, w_err_nxt;
    logic       w_idx;
    logic       w_blank;

    assign w_idx   = r_prev[9];          // one-hot sel: bit 9 set means digit1
    assign w_blank = (r_prev[6:0] == 7'h00);

    always_comb begin
        w_digit0_nxt  = r_digit0;
        w_digit1_nxt  = r_digit1;
        w_dp_nxt      = r_dp;
        w_valid_nxt   = r_valid;
        w_upd_nxt     = 1'b0;
        w_upd_idx_nxt = r_upd_idx;
        w_err_nxt     = 1'b0;
        if (w_eval) begin
            case (r_prev[9:8])
                2'b00: ;                          // inter-digit blanking
                2'b11: w_err_nxt = 1'b1;          // both digits selected
                default: begin
                    if (w_blank) begin
                        w_valid_nxt[w_idx] = 1'b0;
                        w_dp_nxt[w_idx]    = r_prev[7];
                        w_upd_nxt          = 1'b1;
                        w_upd_idx_nxt      = w_idx;
                    end else if (w_hit) begin
                        if (w_idx) begin
                            w_digit1_nxt = w_hex;
                        end else begin
                            w_digit0_nxt = w_hex;
                        end
                        w_valid_nxt[w_idx] = 1'b1;
                        w_dp_nxt[w_idx]    = r_prev[7];
                        w_upd_nxt          = 1'b1;
                        w_upd_idx_nxt      = w_idx;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_digit0  <= 4'h0;
            r_digit1  <= 4'h0;
            r_dp      <= 2'b00;
            r_valid   <= 2'b00;
            r_upd     <= 1'b0;
            r_upd_idx <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_digit0  <= w_digit0_nxt;
            r_digit1  <= w_digit1_nxt;
            r_dp      <= w_dp_nxt;
            r_valid   <= w_valid_nxt;
            r_upd     <= w_upd_nxt;
            r_upd_idx <= w_upd_idx_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign digit0  = r_digit0;
    assign digit1  = r_digit1;
    assign dp      = r_dp;
    assign valid   = r_valid;
    assign upd     = r_upd;
    assign upd_idx = r_upd_idx;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Directed self-checking bench for seg_scan_decoder with default
//            parameters (STABLE_CYCLES=4, active-low com and seg).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [1:0] com     = 2'b11;
    logic [7:0] seg     = 8'hFF;
    logic [3:0] digit0, digit1;
    logic [1:0] dp, valid;
    logic       upd, upd_idx, err;

    seg_scan_decoder #(
        .STABLE_CYCLES (4),
        .COM_ACT_LOW   (1),
        .SEG_ACT_LOW   (1)
    ) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .com     (com),
        .seg     (seg),
        .digit0  (digit0),
        .digit1  (digit1),
        .dp      (dp),
        .valid   (valid),
        .upd     (upd),
        .upd_idx (upd_idx),
        .err     (err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec    = 0;
    int n_bad    = 0;
    int upd_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int bu, be;

    // Pulse counters, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (upd) upd_cnt++;
        if (err) err_cnt++;
        if (upd && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge (E0): apply pins, then wait n edges, end #1 after.
    task automatic drive(input logic [1:0] c, input logic [7:0] s, input int n);
        com = c;
        seg = s;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        // 1. reset, release with idle pins
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        drive(2'b11, 8'hFF, 20);
        check("t1_digit0", 32'(digit0), 32'h0);
        check("t1_digit1", 32'(digit1), 32'h0);
        check("t1_dp",     32'(dp),     32'h0);
        check("t1_valid",  32'(valid),  32'h0);
        check("t1_upd_cnt", 32'(upd_cnt), 32'd0);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);

        // 2. digit0 = '1', latency E0+7
        bu = upd_cnt;
        drive(2'b10, 8'hF9, 6);
        check("t2_upd_early",    32'(upd),    32'h0);
        check("t2_digit0_early", 32'(digit0), 32'h0);
        drive(2'b10, 8'hF9, 1);
        check("t2_upd",     32'(upd),     32'h1);
        check("t2_upd_idx", 32'(upd_idx), 32'h0);
        check("t2_digit0",  32'(digit0),  32'h1);
        check("t2_valid",   32'(valid),   32'h1);
        check("t2_dp",      32'(dp),      32'h0);
        drive(2'b10, 8'hF9, 3);
        check("t2_upd_once", 32'(upd_cnt - bu), 32'd1);

        // 3. alternating scan: digit0='3', digit1='4.'
        bu = upd_cnt;
        be = err_cnt;
        for (int r = 0; r < 2; r++) begin
            drive(2'b10, 8'hB0, 50);
            drive(2'b01, 8'h19, 50);
        end
        check("t3_digit0", 32'(digit0), 32'h3);
        check("t3_digit1", 32'(digit1), 32'h4);
        check("t3_dp",     32'(dp),     32'h2);
        check("t3_valid",  32'(valid),  32'h3);
        check("t3_upd_cnt", 32'(upd_cnt - bu), 32'd4);
        check("t3_err_cnt", 32'(err_cnt - be), 32'd0);

        // 4. 3-cycle glitch on digit1; checked past where a 4-cycle one would commit
        bu = upd_cnt;
        be = err_cnt;
        drive(2'b01, 8'hF9, 3);
        drive(2'b01, 8'h19, 5);
        check("t4_upd_cnt", 32'(upd_cnt - bu), 32'd0);
        check("t4_err_cnt", 32'(err_cnt - be), 32'd0);
        check("t4_digit1",  32'(digit1), 32'h4);
        check("t4_valid",   32'(valid),  32'h3);
        drive(2'b01, 8'h19, 20);

        // 5. both digits selected, then an unknown pattern
        bu = upd_cnt;
        be = err_cnt;
        drive(2'b00, 8'hC0, 20);
        check("t5_err_both",  32'(err_cnt - be), 32'd1);
        check("t5_upd_both",  32'(upd_cnt - bu), 32'd0);
        check("t5_digit0_a",  32'(digit0), 32'h3);
        check("t5_digit1_a",  32'(digit1), 32'h4);
        be = err_cnt;
        drive(2'b10, 8'hB6, 20);
        check("t5_err_bad",   32'(err_cnt - be), 32'd1);
        check("t5_upd_bad",   32'(upd_cnt - bu), 32'd0);
        check("t5_digit0_b",  32'(digit0), 32'h3);
        check("t5_valid_b",   32'(valid),  32'h3);
        check("t5_dp_b",      32'(dp),     32'h2);

        // 6. blank frame on digit0 after a valid value
        drive(2'b10, 8'hF9, 20);
        check("t6_digit0_set", 32'(digit0), 32'h1);
        bu = upd_cnt;
        drive(2'b10, 8'hFF, 20);
        check("t6_blank_upd",  32'(upd_cnt - bu), 32'd1);
        check("t6_blank_valid", 32'(valid),  32'h2);
        check("t6_blank_digit0", 32'(digit0), 32'h1);
        check("t6_blank_dp",   32'(dp),     32'h2);

        // reset mid-count: clears at once, then full latency again
        drive(2'b01, 8'hC0, 3);
        #2;
        sys_rst = 1'b1;
        #1;
        check("t6_rst_digit0", 32'(digit0), 32'h0);
        check("t6_rst_digit1", 32'(digit1), 32'h0);
        check("t6_rst_dp",     32'(dp),     32'h0);
        check("t6_rst_valid",  32'(valid),  32'h0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        drive(2'b01, 8'hC0, 6);
        check("t6_rel_upd_early", 32'(upd),   32'h0);
        check("t6_rel_valid_early", 32'(valid), 32'h0);
        drive(2'b01, 8'hC0, 1);
        check("t6_rel_upd",     32'(upd),     32'h1);
        check("t6_rel_upd_idx", 32'(upd_idx), 32'h1);
        check("t6_rel_valid",   32'(valid),   32'h2);
        check("t6_rel_digit1",  32'(digit1),  32'h0);
        drive(2'b01, 8'hC0, 5);

        check("upd_err_exclusive", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
